// File: rtl/pseudo_spi_rx_sram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_spi_rx_sram_wr_pkg
// Brief    : Shared widths and RX state encodings for the pseudo-SPI receiver.
// Revision : 1.0
// ============================================================================
package pseudo_spi_rx_sram_wr_pkg;

  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int MEMORY_ADDR_WIDTH = 9;
  localparam int RESERVED_DATA_LEN = 8;
  localparam int BIT_CNT_WIDTH     = 4;

  localparam logic [BIT_CNT_WIDTH-1:0] BIT_CNT_FULL = BIT_CNT_WIDTH'(MEMORY_DATA_WIDTH);

  // Encodings are shared with the CPU-side header, so keep them fixed.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'b000,
    RX_WAIT  = 3'b001,
    RX_SHIFT = 3'b011,
    RX_WRITE = 3'b010,
    RX_NEXT  = 3'b110,
    RX_DONE  = 3'b100
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/pseudo_spi_rx_shreg.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_spi_rx_shreg
// Brief    : LSB-first deserialiser with saturating bit counter and SCLK2/LAT
//            rise detectors. Byte and counter outputs include this cycle's shift.
// Revision : 1.0
// ============================================================================
module pseudo_spi_rx_shreg
  import pseudo_spi_rx_sram_wr_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic                         i_sclk2,
  input  logic                         i_lat,
  input  logic                         i_si,
  output logic [MEMORY_DATA_WIDTH-1:0] o_byte,
  output logic [BIT_CNT_WIDTH-1:0]     o_bit_cnt,
  output logic [BIT_CNT_WIDTH-1:0]     o_bit_cnt_upd,
  output logic                         o_sclk2_rise,
  output logic                         o_lat_rise
);

  logic                         r_sclk2_d;
  logic                         r_lat_d;
  logic [MEMORY_DATA_WIDTH-1:0] r_sh;
  logic [BIT_CNT_WIDTH-1:0]     r_cnt;
  logic                         w_shift;

  assign o_sclk2_rise  = i_sclk2 & ~r_sclk2_d;
  assign o_lat_rise    = i_lat & ~r_lat_d;
  assign w_shift       = i_en & o_sclk2_rise;
  assign o_byte        = w_shift ? {i_si, r_sh[MEMORY_DATA_WIDTH-1:1]} : r_sh;
  assign o_bit_cnt     = r_cnt;
  // Saturate at a full byte; extra bits still shift through the register.
  assign o_bit_cnt_upd = (w_shift && (r_cnt != BIT_CNT_FULL)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk2_d <= 1'b0;
      r_lat_d   <= 1'b0;
      r_sh      <= '0;
      r_cnt     <= '0;
    end else begin
      r_sclk2_d <= i_sclk2;
      r_lat_d   <= i_lat;
      r_sh      <= o_byte;
      r_cnt     <= i_clr ? '0 : o_bit_cnt_upd;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pseudo_spi_rx_sram_wr.sv
`default_nettype none
// ============================================================================
// Module   : pseudo_spi_rx_sram_wr
// Brief    : Pseudo-SPI receiver; writes DATA_LEN received bytes to SRAM from
//            ADDR_BGN upward, then reports rx_is_done.
// Revision : 1.0
// ============================================================================
module pseudo_spi_rx_sram_wr
  import pseudo_spi_rx_sram_wr_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SCLK1,
  input  logic                         SCLK2,
  input  logic                         LAT,
  input  logic                         SPI_SI,
  output logic                         CEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         D_WE,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         RDY,
  output logic                         ERR,
  output logic                         rx_is_done
);

  rx_state_e                    r_state;
  rx_state_e                    w_state_nxt;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
  logic [RESERVED_DATA_LEN-1:0] r_len;
  logic [RESERVED_DATA_LEN-1:0] r_byte_cnt;
  logic                         r_cen;
  logic                         r_we;
  logic [MEMORY_ADDR_WIDTH-1:0] r_a;
  logic [MEMORY_DATA_WIDTH-1:0] r_po;
  logic                         r_err;

  logic                         w_shift_en;
  logic                         w_cnt_clr;
  logic                         w_in_shift;
  logic                         w_frame_ok;
  logic                         w_frame_bad;
  logic [MEMORY_DATA_WIDTH-1:0] w_byte;
  logic [BIT_CNT_WIDTH-1:0]     w_bit_cnt;
  logic [BIT_CNT_WIDTH-1:0]     w_bit_cnt_upd;
  logic                         w_sclk2_rise;
  logic                         w_lat_rise;

  assign w_shift_en  = (r_state == RX_WAIT) || (r_state == RX_SHIFT);
  assign w_in_shift  = (r_state == RX_SHIFT) && BGN;
  // LAT is judged against the count that already includes a coincident SCLK2 bit.
  assign w_frame_ok  = w_in_shift && w_lat_rise && (w_bit_cnt_upd == BIT_CNT_FULL);
  assign w_frame_bad = w_in_shift && w_lat_rise && (w_bit_cnt_upd != BIT_CNT_FULL);
  assign w_cnt_clr   = (r_state == RX_IDLE) || (r_state == RX_NEXT) || w_frame_bad;

  pseudo_spi_rx_shreg u_shreg (
    .clk           (CLK),
    .rst           (RST),
    .i_en          (w_shift_en),
    .i_clr         (w_cnt_clr),
    .i_sclk2       (SCLK2),
    .i_lat         (LAT),
    .i_si          (SPI_SI),
    .o_byte        (w_byte),
    .o_bit_cnt     (w_bit_cnt),
    .o_bit_cnt_upd (w_bit_cnt_upd),
    .o_sclk2_rise  (w_sclk2_rise),
    .o_lat_rise    (w_lat_rise)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state != RX_IDLE) && !BGN) begin
      w_state_nxt = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE:  if (BGN) w_state_nxt = (DATA_LEN == '0) ? RX_DONE : RX_WAIT;
        RX_WAIT:  if (w_sclk2_rise) w_state_nxt = RX_SHIFT;
        RX_SHIFT: if (w_lat_rise)
                    w_state_nxt = (w_bit_cnt_upd == BIT_CNT_FULL) ? RX_WRITE : RX_WAIT;
        RX_WRITE: w_state_nxt = RX_NEXT;
        RX_NEXT:  w_state_nxt = ((r_byte_cnt + 1'b1) == r_len) ? RX_DONE : RX_WAIT;
        RX_DONE:  w_state_nxt = RX_DONE;
        default:  w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_cen      <= 1'b1;
      r_we       <= 1'b0;
      r_a        <= '0;
      r_po       <= '0;
      r_err      <= 1'b0;
    end else begin
      // The strobe pair is asserted only for the single cycle spent in WRITE.
      r_cen <= 1'b1;
      r_we  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (BGN) begin
            r_addr     <= ADDR_BGN;
            r_len      <= DATA_LEN;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
          end
        end
        RX_WAIT, RX_SHIFT: begin
          if (SCLK1 && SCLK2) r_err <= 1'b1;
          if ((r_state == RX_SHIFT) && w_sclk2_rise && (w_bit_cnt == BIT_CNT_FULL)) r_err <= 1'b1;
          if (w_frame_bad) r_err <= 1'b1;
          if (w_frame_ok) begin
            r_cen <= 1'b0;
            r_we  <= 1'b1;
            r_a   <= r_addr;
            r_po  <= w_byte;
          end
        end
        RX_NEXT: begin
          r_addr     <= r_addr + 1'b1;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        default: ;
      endcase
      if (w_state_nxt == RX_IDLE) begin
        r_a  <= '0;
        r_po <= '0;
      end
    end
  end

  assign CEN        = r_cen;
  assign D_WE       = r_we;
  assign A          = r_a;
  assign PO         = r_po;
  assign ERR        = r_err;
  assign RDY        = w_shift_en;
  assign rx_is_done = (r_state == RX_DONE);

endmodule
`default_nettype wire
